pio_poll_master: RTL and testbench
==================================

PIO_POLL_MASTER -- requirements
Module: pio_poll_master

Interface
REQ-001 Parameter POLL_CYCLES, default 50000, SHALL set the poll period in clk cycles (legal range 4..2^24).
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 enable  in  1  SHALL permit polling while high.
REQ-005 avm_address  out  1  SHALL be the Avalon-MM word address: 0 = display register, 1 = switch register.
REQ-006 avm_read  out  1  SHALL be the Avalon-MM read strobe.
REQ-007 avm_write  out  1  SHALL be the Avalon-MM write strobe.
REQ-008 avm_writedata  out  8  SHALL be the write data.
REQ-009 avm_readdata  in  8  SHALL be the read data, sampled in the cycle avm_read=1 and avm_waitrequest=0 (zero read latency).
REQ-010 avm_waitrequest  in  1  SHALL be the slave stall; while high, the master SHALL hold address, strobe and data unchanged.
REQ-011 last_sw  out  4  SHALL be the most recently captured switch value.
REQ-012 update_count  out  8  SHALL be the number of completed display writes, wrapping 255->0.

Function
REQ-013 Timer: counts 0..POLL_CYCLES-1 while enable=1 and wraps; held at 0 while enable=0; tick = (count==POLL_CYCLES-1).
REQ-014 FSM states: IDLE, READ, CMP, WRITE.
REQ-015 IDLE: read=write=0, address=0; on tick with enable=1 -> READ next cycle.
REQ-016 READ: address=1, read=1; when waitrequest=0, capture readdata[3:0] into last_sw and go to CMP.
REQ-017 CMP: all strobes 0, one cycle; if captured value differs from the previously captured value, or no write has completed since reset -> WRITE, else -> IDLE.
REQ-018 WRITE: address=0, write=1, writedata per REQ-026/027; when waitrequest=0, increment update_count, set the written-once flag, go to IDLE.
REQ-019 read and write SHALL never be asserted in the same cycle.
REQ-020 A tick in any state other than IDLE SHALL be dropped, not queued.
REQ-021 enable falling during READ or WRITE SHALL NOT abort the transfer; it completes and the FSM returns to IDLE.
REQ-022 With waitrequest=0, minimum tick-to-write latency SHALL be 3 cycles (READ, CMP, WRITE), and the write SHALL complete in the 3rd cycle after the tick.

Reset
REQ-023 reset_n low SHALL immediately force: FSM=IDLE, timer=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=8'h00, last_sw=4'h0, update_count=8'h00, written-once flag cleared.
REQ-024 Reset asserted mid-transfer SHALL drop the strobes asynchronously; no retry after release.
REQ-025 The first poll after reset release SHALL always produce a write (REQ-017).

Configuration
REQ-026 With PIO_POLL_SEG7_EN defined: writedata = {1'b0, seg}, where seg is the active-low {g,f,e,d,c,b,a} pattern of last_sw as hex 0-F (0->7'h40, 1->7'h79, 2->7'h24, 3->7'h30, 8->7'h00, A->7'h08, F->7'h0E).
REQ-027 Without PIO_POLL_SEG7_EN: writedata = {4'h0, last_sw}, with no decoder logic present.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the register address constants (display=0, switch=1) and the 16-entry seg pattern table.
REQ-029 The decoder SHALL be the sub-module hex7seg_dec (4 in, 7 out, combinational), instantiated only under PIO_POLL_SEG7_EN.

Verification
REQ-030 POLL_CYCLES=4, waitrequest=0, readdata=8'h03, enable=1 after reset -> read at address 1, then a write at address 0 with 8'h30 (SEG7 on) or 8'h03 (off); update_count=1.
REQ-031 Same readdata held for 3 further ticks -> 3 more reads, no writes; update_count stays 1.
REQ-032 waitrequest held high 5 cycles during READ, then readdata changes to 8'h0A -> address and read stable for all 5 cycles; the following write carries 8'h08; update_count=2.
REQ-033 enable dropped during a stalled WRITE -> write completes, then no further reads occur while enable=0.
REQ-034 reset_n pulsed low mid-READ -> strobes go to 0 within the same cycle; all outputs at reset values; the next poll writes regardless of value.
REQ-035 258 forced value changes -> update_count wraps to 8'h02.

Source files
------------

// File: rtl/pio_poll_master_pkg.sv
// Shared definitions for the PIO poll master.
//   poll_state_e : FSM state encoding (IDLE, READ, CMP, WRITE)
//   AddrDisplay / AddrSwitch : Avalon-MM word addresses of the two PIO registers
//   Seg7Table    : active-low {g,f,e,d,c,b,a} patterns for hex digits 0-F
//   seg7_lookup  : table lookup helper used by the decoder
package pio_poll_master_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRead  = 2'd1,
      StCmp   = 2'd2,
      StWrite = 2'd3
   } poll_state_e;

   localparam logic AddrDisplay = 1'b0;
   localparam logic AddrSwitch  = 1'b1;

   // Listed from digit F down to digit 0 so that Seg7Table[n] is the pattern for n.
   localparam logic [15:0][6:0] Seg7Table = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic logic [6:0] seg7_lookup(input logic [3:0] nib);
      return Seg7Table[nib];
   endfunction

endpackage

// File: rtl/pio_poll_master_hex7seg_dec.sv
// Hex to seven-segment decoder (combinational).
//   hex_i : 4-bit value 0-F
//   seg_o : active-low {g,f,e,d,c,b,a} segment pattern
module hex7seg_dec
   import pio_poll_master_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = seg7_lookup(hex_i);
   end

endmodule

// File: rtl/pio_poll_master.sv
// Avalon-MM master that periodically reads a switch PIO register and, when the
// value changes (or nothing has been written since reset), writes it to a display
// PIO register.
//
// Optional feature: define PIO_POLL_SEG7_EN to write the value as a seven-segment
// pattern {1'b0, seg} via hex7seg_dec; otherwise the raw nibble {4'h0, last_sw}.
//
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   enable                  : polling permitted while high
//   avm_address             : 0 = display register, 1 = switch register
//   avm_read / avm_write    : Avalon-MM strobes (never both high)
//   avm_writedata           : display data (8'h00 outside a write)
//   avm_readdata            : switch data, zero read latency
//   avm_waitrequest         : slave stall, master holds everything while high
//   last_sw                 : most recently captured switch value
//   update_count            : completed display writes, wraps 255 -> 0
module pio_poll_master
   import pio_poll_master_pkg::*;
#(
   parameter int unsigned POLL_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   output logic       avm_address,
   output logic       avm_read,
   output logic       avm_write,
   output logic [7:0] avm_writedata,
   input  logic [7:0] avm_readdata,
   input  logic       avm_waitrequest,
   output logic [3:0] last_sw,
   output logic [7:0] update_count
);

   localparam int unsigned CntW = $clog2(POLL_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(POLL_CYCLES - 1);

   poll_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      last_sw_q, last_sw_d;
   logic [3:0]      prev_sw_q, prev_sw_d;
   logic [7:0]      upd_cnt_q, upd_cnt_d;
   logic            written_q, written_d;
   logic            tick;
   logic [7:0]      disp_data;
   logic            unused_rd_hi;

   assign unused_rd_hi = ^avm_readdata[7:4];

`ifdef PIO_POLL_SEG7_EN
   logic [6:0] seg;

   hex7seg_dec u_dec (
      .hex_i (last_sw_q),
      .seg_o (seg)
   );

   assign disp_data = {1'b0, seg};
`else
   assign disp_data = {4'h0, last_sw_q};
`endif

   // Poll timer: free-runs 0..POLL_CYCLES-1 while enabled, parked at 0 otherwise.
   always_comb begin
      cnt_d = cnt_q;
      if (!enable) begin
         cnt_d = '0;
      end else if (cnt_q == CntMax) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Gated by enable so a count left at max as enable falls cannot start a poll.
   assign tick = enable && (cnt_q == CntMax);

   always_comb begin
      state_d       = state_q;
      last_sw_d     = last_sw_q;
      prev_sw_d     = prev_sw_q;
      upd_cnt_d     = upd_cnt_q;
      written_d     = written_q;
      avm_read      = 1'b0;
      avm_write     = 1'b0;
      avm_address   = AddrDisplay;
      avm_writedata = 8'h00;

      unique case (state_q)
         StIdle: begin
            // Ticks seen in other states are simply ignored (dropped).
            if (tick) begin
               state_d = StRead;
            end
         end
         StRead: begin
            avm_address = AddrSwitch;
            avm_read    = 1'b1;
            if (!avm_waitrequest) begin
               prev_sw_d = last_sw_q;
               last_sw_d = avm_readdata[3:0];
               state_d   = StCmp;
            end
         end
         StCmp: begin
            if ((last_sw_q != prev_sw_q) || !written_q) begin
               state_d = StWrite;
            end else begin
               state_d = StIdle;
            end
         end
         StWrite: begin
            avm_address   = AddrDisplay;
            avm_write     = 1'b1;
            avm_writedata = disp_data;
            if (!avm_waitrequest) begin
               upd_cnt_d = upd_cnt_q + 8'd1;
               written_d = 1'b1;
               state_d   = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         last_sw_q <= 4'h0;
         prev_sw_q <= 4'h0;
         upd_cnt_q <= 8'h00;
         written_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_sw_q <= last_sw_d;
         prev_sw_q <= prev_sw_d;
         upd_cnt_q <= upd_cnt_d;
         written_q <= written_d;
      end
   end

   assign last_sw      = last_sw_q;
   assign update_count = upd_cnt_q;

endmodule

// File: tb/tb_pio_poll_master.sv
// Directed self-checking bench for pio_poll_master with POLL_CYCLES=4.
// Inputs change 2 time units after a rising edge; a bus monitor samples on the
// falling edge and counts completed transfers.
module tb_pio_poll_master;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       avm_address;
   logic       avm_read;
   logic       avm_write;
   logic [7:0] avm_writedata;
   logic [7:0] avm_readdata;
   logic       avm_waitrequest;
   logic [3:0] last_sw;
   logic [7:0] update_count;

   int tests = 0;
   int fails = 0;

   int         rd_cnt = 0;
   int         wr_cnt = 0;
   int         both_cnt = 0;
   int         cyc = 0;
   int         rd_cyc = 0;
   int         wr_cyc = 0;
   logic       rd_addr = 1'b0;
   logic       wr_addr = 1'b1;
   logic [7:0] wr_data = 8'hxx;

   always #5 clk = ~clk;

   pio_poll_master #(
      .POLL_CYCLES (4)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .enable          (enable),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest),
      .last_sw         (last_sw),
      .update_count    (update_count)
   );

   // Bus monitor: a transfer completes at the rising edge following this sample.
   always @(negedge clk) begin
      cyc++;
      if (avm_read && avm_write) both_cnt++;
      if (avm_read && !avm_waitrequest) begin
         rd_cnt++;
         rd_addr = avm_address;
         rd_cyc  = cyc;
      end
      if (avm_write && !avm_waitrequest) begin
         wr_cnt++;
         wr_addr = avm_address;
         wr_data = avm_writedata;
         wr_cyc  = cyc;
      end
   end

   // Hand-derived expected display bytes for the values the bench writes.
   function automatic logic [7:0] exp_wd(input logic [3:0] v);
`ifdef PIO_POLL_SEG7_EN
      case (v)
         4'h3:    return 8'h30;
         4'h5:    return 8'h12;
         4'hA:    return 8'h08;
         default: return 8'hxx;
      endcase
`else
      return {4'h0, v};
`endif
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_wr(input int base, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         step(1);
         if (wr_cnt != base) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset_n         = 1'b0;
      enable          = 1'b1;
      avm_waitrequest = 1'b0;
      avm_readdata    = 8'hFF;
      step(3);
      tests++;
      if (avm_read !== 1'b0 || avm_write !== 1'b0) begin
         fails++;
         $display("FAIL reset_strobes got rd=%b wr=%b want 0 0", avm_read, avm_write);
      end
      tests++;
      if (avm_address !== 1'b0 || avm_writedata !== 8'h00) begin
         fails++;
         $display("FAIL reset_addr_data got %b/%h want 0/00", avm_address, avm_writedata);
      end
      tests++;
      if (last_sw !== 4'h0 || update_count !== 8'h00) begin
         fails++;
         $display("FAIL reset_regs got sw=%h cnt=%h want 0/00", last_sw, update_count);
      end
   endtask

   task automatic test_first_poll;
      bit ok;
      avm_readdata = 8'h03;
      reset_n      = 1'b1;
      wait_wr(0, 30, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL first_write got timeout want write");
      end
      tests++;
      if (rd_cnt != 1 || rd_addr !== 1'b1) begin
         fails++;
         $display("FAIL first_read got n=%0d addr=%b want 1/1", rd_cnt, rd_addr);
      end
      tests++;
      if (wr_addr !== 1'b0 || wr_data !== exp_wd(4'h3)) begin
         fails++;
         $display("FAIL first_wdata got %b/%h want 0/%h", wr_addr, wr_data, exp_wd(4'h3));
      end
      tests++;
      if (update_count !== 8'd1 || last_sw !== 4'h3) begin
         fails++;
         $display("FAIL first_regs got cnt=%h sw=%h want 01/3", update_count, last_sw);
      end
      tests++;
      if (wr_cyc - rd_cyc != 2) begin
         fails++;
         $display("FAIL read_to_write got %0d want 2", wr_cyc - rd_cyc);
      end
   endtask

   task automatic test_no_change;
      int r0 = rd_cnt;
      int w0 = wr_cnt;
      for (int k = 0; k < 40 && rd_cnt < r0 + 3; k++) step(1);
      step(3);
      tests++;
      if (rd_cnt < r0 + 3) begin
         fails++;
         $display("FAIL same_reads got %0d want %0d", rd_cnt - r0, 3);
      end
      tests++;
      if (wr_cnt != w0 || update_count !== 8'd1) begin
         fails++;
         $display("FAIL same_nowrite got w=%0d cnt=%h want 0/01", wr_cnt - w0, update_count);
      end
   endtask

   task automatic test_stall_read;
      bit ok;
      int bad = 0;
      int r0;
      avm_waitrequest = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step(1);
         if (avm_read === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL stall_read_start got timeout want read");
      end
      r0 = rd_cnt;
      for (int k = 0; k < 5; k++) begin
         if (avm_read !== 1'b1 || avm_address !== 1'b1 || avm_write !== 1'b0) bad++;
         step(1);
      end
      tests++;
      if (bad != 0 || rd_cnt != r0) begin
         fails++;
         $display("FAIL stall_hold got bad=%0d done=%0d want 0/0", bad, rd_cnt - r0);
      end
      avm_readdata    = 8'h0A;
      avm_waitrequest = 1'b0;
      wait_wr(wr_cnt, 10, ok);
      tests++;
      if (!ok || wr_data !== exp_wd(4'hA)) begin
         fails++;
         $display("FAIL stall_wdata got ok=%b %h want 1 %h", ok, wr_data, exp_wd(4'hA));
      end
      tests++;
      if (update_count !== 8'd2 || last_sw !== 4'hA) begin
         fails++;
         $display("FAIL stall_regs got cnt=%h sw=%h want 02/A", update_count, last_sw);
      end
   endtask

   task automatic test_enable_drop;
      bit ok;
      int bad = 0;
      int base;
      int r0;
      avm_readdata = 8'h05;
      ok = 1'b0;
      for (int k = 0; k < 30; k++) begin
         step(1);
         if (avm_write === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL drop_write_start got timeout want write");
      end
      base            = wr_cnt;
      avm_waitrequest = 1'b1;
      enable          = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(1);
         if (avm_write !== 1'b1 || avm_address !== 1'b0 || avm_writedata !== exp_wd(4'h5)) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL drop_write_hold got bad=%0d want 0", bad);
      end
      avm_waitrequest = 1'b0;
      wait_wr(base, 5, ok);
      tests++;
      if (!ok || update_count !== 8'd3) begin
         fails++;
         $display("FAIL drop_complete got ok=%b cnt=%h want 1/03", ok, update_count);
      end
      r0 = rd_cnt;
      step(20);
      tests++;
      if (rd_cnt != r0 || avm_read !== 1'b0) begin
         fails++;
         $display("FAIL drop_no_reads got %0d want 0", rd_cnt - r0);
      end
   endtask

   task automatic test_reset_mid_read;
      bit ok;
      enable          = 1'b1;
      avm_waitrequest = 1'b1;
      avm_readdata    = 8'h05;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step(1);
         if (avm_read === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL rst_read_start got timeout want read");
      end
      reset_n = 1'b0;
      #1;
      tests++;
      if (avm_read !== 1'b0 || avm_write !== 1'b0 || avm_address !== 1'b0) begin
         fails++;
         $display("FAIL rst_async got rd=%b wr=%b a=%b want 0 0 0", avm_read, avm_write,
                  avm_address);
      end
      tests++;
      if (update_count !== 8'h00 || last_sw !== 4'h0 || avm_writedata !== 8'h00) begin
         fails++;
         $display("FAIL rst_regs got cnt=%h sw=%h wd=%h want 00/0/00", update_count, last_sw,
                  avm_writedata);
      end
      step(2);
      reset_n         = 1'b1;
      avm_waitrequest = 1'b0;
      wait_wr(wr_cnt, 30, ok);
      tests++;
      if (!ok || update_count !== 8'd1 || wr_data !== exp_wd(4'h5)) begin
         fails++;
         $display("FAIL rst_rewrite got ok=%b cnt=%h wd=%h want 1/01/%h", ok, update_count,
                  wr_data, exp_wd(4'h5));
      end
   endtask

   task automatic test_wrap;
      bit ok;
      int timeouts = 0;
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      for (int i = 0; i < 258; i++) begin
         avm_readdata = (i % 2 == 1) ? 8'h09 : 8'h06;
         wait_wr(wr_cnt, 20, ok);
         if (!ok) timeouts++;
      end
      tests++;
      if (timeouts != 0) begin
         fails++;
         $display("FAIL wrap_writes got %0d timeouts want 0", timeouts);
      end
      tests++;
      if (update_count !== 8'h02) begin
         fails++;
         $display("FAIL wrap_count got %h want 02", update_count);
      end
      tests++;
      if (both_cnt != 0) begin
         fails++;
         $display("FAIL rd_wr_exclusive got %0d overlaps want 0", both_cnt);
      end
   endtask

   initial begin
      reset_n         = 1'b0;
      enable          = 1'b0;
      avm_waitrequest = 1'b0;
      avm_readdata    = 8'h00;
      test_reset();
      test_first_poll();
      test_no_change();
      test_stall_read();
      test_enable_drop();
      test_reset_mid_read();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
